// File: rtl/weave_draft_tx.sv
// Woven-draft bitmap transmitter.
// Generates plain, twill 2/2, satin-5 or rotated custom rows on the fly and
// shifts them out one row at a time over a source-clocked serial link
// (data, clock, frame), waiting for a receiver acknowledge after every row.
module weave_draft_tx #(
  parameter int WIDTH       = 8,
  parameter int ROWS        = 8,
  parameter int BIT_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       pattern,
  input  logic [WIDTH-1:0] custom_row,
  input  logic             tx_ack,
  output logic             tx_data,
  output logic             tx_clk,
  output logic             tx_frame,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PW = (BIT_CYCLES  > 1) ? $clog2(BIT_CYCLES)  : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [4:0]    LAST_COL   = 5'(WIDTH - 1);
  localparam logic [4:0]    LAST_ROW   = 5'(ROWS - 1);
  localparam logic [4:0]    WIDTH_5    = 5'(WIDTH);
  localparam logic [PW-1:0] LAST_PHASE = PW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] LAST_TICK  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       row_q, row_d;
  logic [4:0]       col_q, col_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic [1:0]       pattern_q;
  logic [WIDTH-1:0] customRow_q;
  logic             txData_q;
  logic             latchCfg;
  logic             loadBit;

  logic [5:0]       diagSum;
  logic [6:0]       satinSum;
  logic [4:0]       rotAmt;
  logic [WIDTH-1:0] rotated;
  logic [WIDTH-1:0] shifted;
  logic             cellBit;

  // Next-state logic: walks columns within a row, rows within a frame, and
  // handles the ack wait with its timeout; loadBit marks every LOW entry.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    phase_d  = phase_q;
    timer_d  = timer_q;
    err_d    = err_q;
    latchCfg = 1'b0;
    loadBit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latchCfg = 1'b1;
          err_d    = 1'b0;
          row_d    = 5'd0;
          col_d    = 5'd0;
          phase_d  = '0;
          timer_d  = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        row_d   = 5'd0;
        col_d   = 5'd0;
        phase_d = '0;
        loadBit = 1'b1;
        state_d = S_LOW;
      end
      S_LOW: begin
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          state_d = S_HIGH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          if (col_q < LAST_COL) begin
            col_d   = col_q + 5'd1;
            loadBit = 1'b1;
            state_d = S_LOW;
          end else begin
            timer_d = '0;
            state_d = S_WAIT_ACK;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (tx_ack) begin
          col_d   = 5'd0;
          timer_d = '0;
          if (row_q < LAST_ROW) begin
            row_d   = row_q + 5'd1;
            loadBit = 1'b1;
            state_d = S_LOW;
          end else begin
            state_d = S_DONE;
          end
        end else if (timer_q == LAST_TICK) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Cell generator: the draft bit for the row/column about to be sent.
  always_comb begin
    diagSum  = {1'b0, row_d} + {1'b0, col_d};
    satinSum = {1'b0, col_d, 1'b0} + {2'b00, row_d};
    rotAmt   = row_d % WIDTH_5;
    rotated  = (customRow_q << rotAmt) | (customRow_q >> (WIDTH_5 - rotAmt));
    shifted  = rotated >> col_d;
    case (pattern_q)
      2'd0:    cellBit = diagSum[0];
      2'd1:    cellBit = ~diagSum[1];
      2'd2:    cellBit = ((satinSum % 7'd5) == 7'd0);
      default: cellBit = shifted[0];
    endcase
  end

  // State, counters, latched configuration and the registered data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= 5'd0;
      col_q       <= 5'd0;
      phase_q     <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      pattern_q   <= 2'd0;
      customRow_q <= '0;
      txData_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      if (latchCfg) begin
        pattern_q   <= pattern;
        customRow_q <= custom_row;
        txData_q    <= 1'b0;
      end
      if (loadBit) begin
        txData_q <= cellBit;
      end
    end
  end

  assign tx_data  = txData_q;
  assign tx_clk   = (state_q == S_HIGH);
  assign tx_frame = (state_q == S_LOAD) || (state_q == S_LOW) ||
                    (state_q == S_HIGH) || (state_q == S_WAIT_ACK);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_weave_draft_tx.sv
// Directed testbench for weave_draft_tx with default parameters.
// A receiver model captures rows on tx_clk rises and returns acks.
module tb_weave_draft_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] pattern;
  logic [7:0] custom_row;
  logic       tx_ack;
  logic       tx_data;
  logic       tx_clk;
  logic       tx_frame;
  logic       busy;
  logic       done;
  logic       err;

  int testsRun;
  int testsFailed;

  logic [7:0] rowsCap [8];
  int         rowsGot;
  int         doneCnt;
  int         frameBad;
  int         waitLen;
  logic       errAtLoad;
  bit         frameTimedOut;

  logic [7:0] expPlain  [8] = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
  logic [7:0] expTwill  [8] = '{8'h33, 8'h99, 8'hCC, 8'h66, 8'h33, 8'h99, 8'hCC, 8'h66};
  logic [7:0] expSatin  [8] = '{8'h21, 8'h84, 8'h10, 8'h42, 8'h08, 8'h21, 8'h84, 8'h10};
  logic [7:0] expCust01 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] expCust81 [8] = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};

  weave_draft_tx #(
    .WIDTH(8), .ROWS(8), .BIT_CYCLES(2), .ACK_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .custom_row(custom_row), .tx_ack(tx_ack), .tx_data(tx_data),
    .tx_clk(tx_clk), .tx_frame(tx_frame), .busy(busy), .done(done), .err(err)
  );

  // 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runs one frame as the receiver: captures bits, acks 3 cycles into
  // WAIT_ACK when giveAck is set, optionally glitches start/tx_ack while busy.
  task automatic runFrame(input logic [1:0] pat, input logic [7:0] cust,
                          input bit giveAck, input bit glitch);
    int bitCnt;
    int waitCycles;
    int cyc;
    logic prevClk;
    logic [7:0] shreg;
    bit rowPending;
    bit realAck;
    bit glitchOn;
    rowsGot = 0; doneCnt = 0; frameBad = 0; waitLen = 0;
    frameTimedOut = 1'b1;
    bitCnt = 0; waitCycles = 0; prevClk = 1'b0; shreg = 8'h00;
    rowPending = 1'b0; realAck = 1'b0; glitchOn = 1'b0;
    @(negedge clk);
    pattern = pat; custom_row = cust; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    errAtLoad = err;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (tx_ack) begin
        tx_ack = 1'b0;
        if (realAck) begin
          rowPending = 1'b0;
          waitCycles = 0;
          realAck    = 1'b0;
        end
      end
      if (glitchOn) begin
        start = 1'b0;
        glitchOn = 1'b0;
      end
      if (tx_clk && !prevClk) begin
        shreg[bitCnt] = tx_data;
        bitCnt++;
        if (bitCnt == 8) begin
          if (rowsGot < 8) rowsCap[rowsGot] = shreg;
          rowsGot++;
          bitCnt = 0;
          rowPending = 1'b1;
        end
      end else if (rowPending && !tx_clk && busy && tx_frame) begin
        waitCycles++;
        waitLen = waitCycles;
        if (giveAck && waitCycles == 3) begin
          tx_ack  = 1'b1;
          realAck = 1'b1;
        end
      end
      if (glitch && !rowPending && !tx_ack && tx_frame && (cyc % 5 == 2)) begin
        tx_ack   = 1'b1;
        start    = 1'b1;
        glitchOn = 1'b1;
      end
      if (done) begin
        doneCnt++;
        if (tx_frame) frameBad++;
      end
      prevClk = tx_clk;
      if (!busy) begin
        frameTimedOut = 1'b0;
        break;
      end
      @(negedge clk);
    end
    tx_ack = 1'b0;
    start  = 1'b0;
    if (frameTimedOut) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL frame_timeout: busy still %b after 3000 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    testsRun++;
    if ({tx_data, tx_clk, tx_frame, busy, done, err} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %b, required 000000",
               {tx_data, tx_clk, tx_frame, busy, done, err});
    end
  endtask

  task automatic test_plain();
    runFrame(2'd0, 8'h00, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      testsRun++;
      if (rowsCap[r] !== expPlain[r]) begin
        testsFailed++;
        $display("[TB] FAIL plain_row%0d: got %h, required %h", r, rowsCap[r], expPlain[r]);
      end
    end
    testsRun++;
    if (rowsGot !== 8 || doneCnt !== 1) begin
      testsFailed++;
      $display("[TB] FAIL plain_done: rows %0d done %0d, required 8 and 1", rowsGot, doneCnt);
    end
    testsRun++;
    if (err !== 1'b0 || frameBad !== 0) begin
      testsFailed++;
      $display("[TB] FAIL plain_err_frame: err %b frame-with-done %0d, required 0 and 0", err, frameBad);
    end
  endtask

  task automatic test_twill_satin();
    runFrame(2'd1, 8'h00, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      testsRun++;
      if (rowsCap[r] !== expTwill[r]) begin
        testsFailed++;
        $display("[TB] FAIL twill_row%0d: got %h, required %h", r, rowsCap[r], expTwill[r]);
      end
    end
    runFrame(2'd2, 8'h00, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      testsRun++;
      if (rowsCap[r] !== expSatin[r]) begin
        testsFailed++;
        $display("[TB] FAIL satin_row%0d: got %h, required %h", r, rowsCap[r], expSatin[r]);
      end
    end
  endtask

  task automatic test_custom();
    runFrame(2'd3, 8'h01, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      testsRun++;
      if (rowsCap[r] !== expCust01[r]) begin
        testsFailed++;
        $display("[TB] FAIL custom01_row%0d: got %h, required %h", r, rowsCap[r], expCust01[r]);
      end
    end
    runFrame(2'd3, 8'h81, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      testsRun++;
      if (rowsCap[r] !== expCust81[r]) begin
        testsFailed++;
        $display("[TB] FAIL custom81_row%0d: got %h, required %h", r, rowsCap[r], expCust81[r]);
      end
    end
  endtask

  task automatic test_timeout();
    runFrame(2'd0, 8'h00, 1'b0, 1'b0);
    testsRun++;
    if (waitLen !== 64) begin
      testsFailed++;
      $display("[TB] FAIL timeout_len: got %0d cycles, required 64", waitLen);
    end
    testsRun++;
    if ({err, tx_frame, busy} !== 3'b100 || doneCnt !== 0) begin
      testsFailed++;
      $display("[TB] FAIL timeout_state: err/frame/busy %b done %0d, required 100 and 0",
               {err, tx_frame, busy}, doneCnt);
    end
    runFrame(2'd0, 8'h00, 1'b1, 1'b0);
    testsRun++;
    if (errAtLoad !== 1'b0 || err !== 1'b0 || doneCnt !== 1) begin
      testsFailed++;
      $display("[TB] FAIL timeout_recover: errAtLoad %b err %b done %0d, required 0 0 1",
               errAtLoad, err, doneCnt);
    end
    testsRun++;
    if (rowsCap[7] !== 8'h55) begin
      testsFailed++;
      $display("[TB] FAIL timeout_recover_row7: got %h, required 55", rowsCap[7]);
    end
  endtask

  task automatic test_timing();
    logic expClk  [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic expData [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    pattern = 2'd3; custom_row = 8'h05; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      testsRun++;
      if (tx_clk !== expClk[i] || tx_frame !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL timing_clk_cycle%0d: clk %b frame %b, required %b 1",
                 i + 1, tx_clk, tx_frame, expClk[i]);
      end
      if (i > 0) begin
        testsRun++;
        if (tx_data !== expData[i]) begin
          testsFailed++;
          $display("[TB] FAIL timing_data_cycle%0d: got %b, required %b", i + 1, tx_data, expData[i]);
        end
      end
    end
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mid_reset();
    int rises;
    logic prevClk;
    rises = 0; prevClk = 1'b0;
    @(negedge clk);
    pattern = 2'd0; custom_row = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && rises < 4; i++) begin
      @(negedge clk);
      if (tx_clk && !prevClk) rises++;
      prevClk = tx_clk;
    end
    testsRun++;
    if (rises !== 4 || {tx_data, tx_clk, tx_frame} !== 3'b111) begin
      testsFailed++;
      $display("[TB] FAIL midreset_pre: rises %0d data/clk/frame %b, required 4 and 111",
               rises, {tx_data, tx_clk, tx_frame});
    end
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if ({tx_data, tx_clk, tx_frame, busy, done, err} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_async: got %b, required 000000",
               {tx_data, tx_clk, tx_frame, busy, done, err});
    end
    @(negedge clk);
    rst = 1'b0;
    runFrame(2'd0, 8'h00, 1'b1, 1'b0);
    testsRun++;
    if (rowsGot !== 8 || doneCnt !== 1 || rowsCap[0] !== 8'hAA || rowsCap[3] !== 8'h55) begin
      testsFailed++;
      $display("[TB] FAIL midreset_after: rows %0d done %0d r0 %h r3 %h, required 8 1 aa 55",
               rowsGot, doneCnt, rowsCap[0], rowsCap[3]);
    end
  endtask

  task automatic test_glitches();
    runFrame(2'd1, 8'h00, 1'b1, 1'b1);
    for (int r = 0; r < 8; r++) begin
      testsRun++;
      if (rowsCap[r] !== expTwill[r]) begin
        testsFailed++;
        $display("[TB] FAIL glitch_row%0d: got %h, required %h", r, rowsCap[r], expTwill[r]);
      end
    end
    testsRun++;
    if (rowsGot !== 8 || doneCnt !== 1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL glitch_done: rows %0d done %0d busy %b, required 8 1 0", rowsGot, doneCnt, busy);
    end
  endtask

  // Test sequence.
  initial begin
    testsRun = 0; testsFailed = 0;
    rst = 1'b1; start = 1'b0; pattern = 2'd0; custom_row = 8'h00; tx_ack = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_plain();
    test_twill_satin();
    test_custom();
    test_timeout();
    test_timing();
    test_mid_reset();
    test_glitches();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/weave_draft_tx.md
Name: weave_draft_tx

Overview:
Transmits a woven-draft bitmap (ROWS × WIDTH threads) to an external loom controller or display over a 4-wire source-clocked link: data, clock, frame and ack. It generates plain, twill 2/2, satin-5 or rotated custom rows on the fly and sends them one row at a time, waiting for a receiver ack after each row. It sits behind the top-level pin wrapper and drives the bidirectional IO output path, which until now has been tied off.

Parameters:
WIDTH, 8, threads (bits) per row; must be ≥ 2 and ≤ 16
ROWS, 8, rows per frame; must be ≥ 1 and ≤ 16
BIT_CYCLES, 2, clk cycles per tx_clk phase (low phase and high phase each); must be ≥ 1
ACK_TIMEOUT, 64, max clk cycles spent in WAIT_ACK before abort; must be ≥ 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin a frame; honoured only in IDLE
pattern  in  2  0 plain, 1 twill 2/2, 2 satin-5, 3 custom; sampled with start
custom_row  in  WIDTH  base row for pattern 3; sampled with start
tx_ack  in  1  receiver row acknowledge, level-sensitive
tx_data  out  1  serial row bit, LSB (column 0) first
tx_clk  out  1  bit clock; receiver samples tx_data on its rising edge
tx_frame  out  1  high for the whole frame transfer
busy  out  1  high whenever state ≠ IDLE
done  out  1  one-cycle pulse when a frame completes successfully
err  out  1  sticky ack-timeout flag; cleared by the next accepted start

Behaviour:
- Reset (async, immediate, including mid-frame): state IDLE; tx_data, tx_clk, tx_frame, busy, done and err all 0; row, column and timer counters 0.
- States: IDLE → LOAD → LOW ⇄ HIGH → WAIT_ACK → (LOW | DONE) → IDLE.
- IDLE:
  - start=1 latches pattern and custom_row, clears err, and moves to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle):
  - tx_frame=1, tx_clk=0, row r=0, column c=0.
- LOW (BIT_CYCLES cycles):
  - tx_clk=0.
  - tx_data = cell(r,c), registered, and stable from the first LOW cycle through the end of HIGH.
- HIGH (BIT_CYCLES cycles):
  - tx_clk=1.
  - Then, if c < WIDTH-1: c increments and the state returns to LOW.
  - Otherwise the state goes to WAIT_ACK with tx_clk=0.
- WAIT_ACK:
  - tx_clk=0; the timer counts cycles.
  - tx_ack=1 (any cycle, including the first): c=0.
    - If r < ROWS-1: r increments and the state goes to LOW.
    - Otherwise the state goes to DONE.
  - Timer reaches ACK_TIMEOUT without ack: err=1, tx_frame=0, and the state goes to IDLE (abort, no done).
- DONE (1 cycle):
  - done=1, tx_frame=0, then IDLE.
- A tx_ack level seen outside WAIT_ACK is ignored.
- Cell function; counters are unsigned and mod arithmetic uses the full counter width with no overflow:
  - plain: (r+c) mod 2.
  - twill: ((r+c) mod 4) < 2.
  - satin: ((2c+r) mod 5) == 0.
  - custom: bit c of custom_row rotated left by (r mod WIDTH).
- Timing: with start high at cycle 0, LOAD is at cycle 1 and the first tx_clk rise is at cycle 2+BIT_CYCLES.
- One row costs 2·BIT_CYCLES·WIDTH cycles plus ack latency.
- busy is high from LOAD through DONE inclusive.
- start asserted in the same cycle as the DONE→IDLE transition is ignored; it must be seen while in IDLE.

Test Plan:
- Plain, defaults, ack returned 3 cycles after each WAIT_ACK entry → receiver captures rows 0xAA, 0x55 repeating over 8 rows; done pulses once; err=0; tx_frame falls together with done.
- Twill → row0 0x33, row1 0x99, row2 0xCC, row3 0x66, then repeating; satin → row0 0x21 (columns 0 and 5), row1 0x84.
- Custom 0x01 → row r = 1<<r, giving 0x01 … 0x80; custom 0x81 with ROWS=2 → 0x81, then 0x03.
- No ack ever → WAIT_ACK lasts exactly 64 cycles, then err=1, tx_frame=0, busy=0, no done. A following start clears err and completes normally.
- Reset asserted mid-row (during HIGH of bit 3) → all outputs 0 in the same cycle without waiting for a clock edge; after release, start runs a full clean frame.
- start pulses while busy and tx_ack glitches during LOW/HIGH → no effect on the bitstream; timing check confirms the first tx_clk rise at cycle 4 (BIT_CYCLES=2) and 2 cycles per phase.
